// File: rtl/udp_tx_frame_buffer.sv
// Store-and-forward UDP TX payload buffer: data FIFO plus frame length FIFO.
// Optional statistics counters are built when UDP_TX_BUF_STATS_EN is defined.
module udp_tx_frame_buffer #(
    parameter int P_DATA_DEPTH  = 512,
    parameter int P_FRAME_DEPTH = 16,
    parameter int P_MAX_LEN     = 1472
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] s_axis_app_data,
    input  logic [7:0]  s_axis_app_keep,
    input  logic        s_axis_app_last,
    input  logic        s_axis_app_valid,
    output logic        s_axis_app_ready,
    output logic [63:0] m_axis_udp_data,
    output logic [31:0] m_axis_udp_user,
    output logic [7:0]  m_axis_udp_keep,
    output logic        m_axis_udp_last,
    output logic        m_axis_udp_valid,
    input  logic        m_axis_udp_ready,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam int AW = $clog2(P_DATA_DEPTH);
    localparam int FW = $clog2(P_FRAME_DEPTH);
    localparam logic [AW:0] D_FULL = (AW+1)'(P_DATA_DEPTH);
    localparam logic [AW:0] D_LAST = (AW+1)'(P_DATA_DEPTH - 1);
    localparam logic [AW:0] D_ONE  = 1;
    localparam logic [FW:0] F_FULL = (FW+1)'(P_FRAME_DEPTH);
    localparam logic [FW:0] F_ONE  = 1;
    localparam logic [15:0] MAX_LEN = 16'(P_MAX_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    logic [72:0] data_mem [P_DATA_DEPTH];
    logic [15:0] len_mem  [P_FRAME_DEPTH];

    logic [AW:0] wr_ptr, commit_ptr, rd_ptr, used;
    logic [FW:0] len_wr, len_rd, len_rel;
    logic        discard;
    logic [15:0] byte_cnt, frame_len;
    logic [16:0] sum;
    logic        len_empty, len_full, len_ok, would_fill;
    logic        in_hs, out_hs, frame_done;
    logic        mem_we, commit, drop;
    logic        load, adv, stop;
    logic [72:0] rd_word;
    state_t      state, state_n;

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, k[i]};
        return c;
    endfunction

    assign used       = wr_ptr - rd_ptr;
    assign len_empty  = (len_wr == len_rd);
    // An entry stays reserved until its frame has left on the output port.
    assign len_full   = ((len_wr - len_rel) == F_FULL);
    assign s_axis_app_ready = i_rst &
        (discard | ((used != D_FULL) & ~len_full));

    assign sum        = {1'b0, byte_cnt} + {13'd0, popcount8(s_axis_app_keep)};
    assign frame_len  = sum[16] ? 16'hFFFF : sum[15:0];
    assign len_ok     = (frame_len != 16'd0) && (frame_len <= MAX_LEN);
    assign would_fill = ~s_axis_app_last && (used == D_LAST);

    assign in_hs  = s_axis_app_valid & s_axis_app_ready;
    assign mem_we = in_hs & ~discard & (s_axis_app_last ? len_ok : ~would_fill);
    assign commit = in_hs & ~discard & s_axis_app_last & len_ok;
    assign drop   = in_hs & ~discard & (s_axis_app_last ? ~len_ok : would_fill);

    assign out_hs     = m_axis_udp_valid & m_axis_udp_ready;
    assign frame_done = out_hs & m_axis_udp_last;
    assign rd_word    = data_mem[rd_ptr[AW-1:0]];

    // Storage arrays: beats and committed lengths.
    always_ff @(posedge i_clk) begin
        if (mem_we) data_mem[wr_ptr[AW-1:0]] <=
            {s_axis_app_last, s_axis_app_keep, s_axis_app_data};
        if (commit) len_mem[len_wr[FW-1:0]] <= frame_len;
    end

    // Write side: accumulate frame, commit or rewind at its end.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            len_wr     <= '0;
            byte_cnt   <= '0;
            discard    <= 1'b0;
        end else if (in_hs) begin
            if (discard) begin
                if (s_axis_app_last) discard <= 1'b0;
            end else if (drop) begin
                wr_ptr   <= commit_ptr;
                byte_cnt <= '0;
                discard  <= ~s_axis_app_last;
            end else begin
                wr_ptr   <= wr_ptr + D_ONE;
                byte_cnt <= s_axis_app_last ? 16'd0 : frame_len;
                if (s_axis_app_last) begin
                    commit_ptr <= wr_ptr + D_ONE;
                    len_wr     <= len_wr + F_ONE;
                end
            end
        end
    end

    // Output FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_n;
    end

    // Output FSM next state; the next frame's load is folded into the
    // final handshake so consecutive frames stream without a bubble.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        adv     = 1'b0;
        stop    = 1'b0;
        unique case (state)
            IDLE: if (!len_empty) state_n = LOAD;
            LOAD: begin
                load    = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                if (out_hs) begin
                    if (!m_axis_udp_last) begin
                        adv = 1'b1;
                    end else if (!len_empty) begin
                        load = 1'b1;
                    end else begin
                        stop    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output beat register and read-side pointers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_ptr           <= '0;
            len_rd           <= '0;
            len_rel          <= '0;
            m_axis_udp_data  <= '0;
            m_axis_udp_keep  <= '0;
            m_axis_udp_last  <= 1'b0;
            m_axis_udp_user  <= '0;
            m_axis_udp_valid <= 1'b0;
        end else begin
            if (load) begin
                {m_axis_udp_last, m_axis_udp_keep, m_axis_udp_data} <= rd_word;
                m_axis_udp_user  <= {len_mem[len_rd[FW-1:0]], 16'd0};
                m_axis_udp_valid <= 1'b1;
                rd_ptr           <= rd_ptr + D_ONE;
                len_rd           <= len_rd + F_ONE;
            end else if (adv) begin
                {m_axis_udp_last, m_axis_udp_keep, m_axis_udp_data} <= rd_word;
                rd_ptr <= rd_ptr + D_ONE;
            end else if (stop) begin
                m_axis_udp_valid <= 1'b0;
                m_axis_udp_last  <= 1'b0;
            end
            if (frame_done) len_rel <= len_rel + F_ONE;
        end
    end

`ifdef UDP_TX_BUF_STATS_EN
    logic [15:0] frame_cnt, drop_cnt;

    // Forwarded and dropped frame counters, wrapping.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            if (drop)       drop_cnt  <= drop_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = frame_cnt;
    assign o_drop_cnt  = drop_cnt;
`else
    assign o_frame_cnt = 16'd0;
    assign o_drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_udp_tx_frame_buffer.sv
// Bench for udp_tx_frame_buffer: frame-level model with queue scoreboard.
// Counter expectations follow UDP_TX_BUF_STATS_EN when it is defined.
module tb_udp_tx_frame_buffer;

    localparam int MAX_LEN = 1472;
`ifdef UDP_TX_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [31:0] user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_last, s_valid, s_ready;
    logic [63:0] m_data;
    logic [31:0] m_user;
    logic [7:0]  m_keep;
    logic        m_last, m_valid, m_ready;
    logic [15:0] frame_cnt, drop_cnt;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int frames_exp = 0;
    int drop_exp = 0;
    int rmode = 0;

    always #5 clk = ~clk;

    udp_tx_frame_buffer dut (
        .i_clk(clk), .i_rst(rst_n),
        .s_axis_app_data(s_data), .s_axis_app_keep(s_keep),
        .s_axis_app_last(s_last), .s_axis_app_valid(s_valid),
        .s_axis_app_ready(s_ready),
        .m_axis_udp_data(m_data), .m_axis_udp_user(m_user),
        .m_axis_udp_keep(m_keep), .m_axis_udp_last(m_last),
        .m_axis_udp_valid(m_valid), .m_axis_udp_ready(m_ready),
        .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt)
    );

    function automatic int pc(input logic [7:0] k);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(k[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Output ready pattern: 0 high, 1 low, 2 toggle, 3 random.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_ready = 1'b1;
                1: m_ready = 1'b0;
                2: m_ready = ~m_ready;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Compare process: every output handshake and every stalled cycle.
    initial begin
        beat_t b;
        bit stall = 1'b0;
        logic [63:0] pd;
        logic [7:0] pk;
        logic pl;
        logic [31:0] pu;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    checks++;
                    if (!(m_valid === 1'b1 && m_data === pd && m_keep === pk &&
                          m_last === pl && m_user === pu)) begin
                        errors++;
                        $display("FAIL hold: v=%b d=%h k=%h l=%b u=%h required v=1 d=%h k=%h l=%b u=%h",
                                 m_valid, m_data, m_keep, m_last, m_user, pd, pk, pl, pu);
                    end
                end
                if (m_valid && m_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat: unexpected d=%h k=%h l=%b u=%h required none",
                                 m_data, m_keep, m_last, m_user);
                    end else begin
                        b = exp_q.pop_front();
                        if (m_data !== b.data || m_keep !== b.keep ||
                            m_last !== b.last || m_user !== b.user) begin
                            errors++;
                            $display("FAIL beat: d=%h k=%h l=%b u=%h required d=%h k=%h l=%b u=%h",
                                     m_data, m_keep, m_last, m_user,
                                     b.data, b.keep, b.last, b.user);
                        end
                    end
                end
                stall = m_valid && !m_ready;
                pd = m_data;
                pk = m_keep;
                pl = m_last;
                pu = m_user;
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic l, output bit ok);
        int n = 0;
        s_data = d;
        s_keep = k;
        s_last = l;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready: got timeout required accept");
            s_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
    endtask

    // Sends a frame; non-last beats full, last beat keep lk.
    task automatic send_frame(input int nb, input logic [7:0] lk,
                              input bit gaps);
        beat_t fr[$];
        beat_t b;
        bit ok;
        int len;
        len = 8 * (nb - 1) + pc(lk);
        for (int i = 0; i < nb; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = (i == nb - 1) ? lk : 8'hFF;
            b.last = (i == nb - 1);
            b.user = {16'(len), 16'd0};
            fr.push_back(b);
        end
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_beat(fr[i].data, fr[i].keep, fr[i].last, ok);
            if (!ok) return;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        if (len >= 1 && len <= MAX_LEN) begin
            foreach (fr[i]) exp_q.push_back(fr[i]);
            frames_exp++;
        end else begin
            drop_exp++;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_cnt(input string name);
        check({name, "_frames"}, 64'(frame_cnt),
              STATS ? 64'(16'(frames_exp)) : 64'd0);
        check({name, "_drops"}, 64'(drop_cnt),
              STATS ? 64'(16'(drop_exp)) : 64'd0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ktab [9];
        bit ok;
        int n;
        int run;
        ktab = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        rst_n = 1'b0;
        s_data = '0;
        s_keep = '0;
        s_last = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", m_data, 64'd0);
        check("rst_user", 64'(m_user), 64'd0);
        check("rst_keep_last", 64'({m_keep, m_last}), 64'd0);
        check("rst_cnts", 64'({frame_cnt, drop_cnt}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat frame of 18 bytes, latency after last.
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_frame(3, 8'hC0, 1'b0);
        wait_valid(n);
        checks++;
        if (n > 3) begin
            errors++;
            $display("FAIL latency: got %0d cycles required <= 3", n);
        end
        check("user_18", 64'(m_user), 64'h0012_0000);
        drain("drain_3beat");
        check_cnt("cnt_3beat");

        // Oversize 1480-byte frame dropped, then an 8-byte frame.
        send_frame(185, 8'hFF, 1'b0);
        send_frame(1, 8'hFF, 1'b0);
        wait_valid(n);
        check("user_8", 64'(m_user), 64'h0008_0000);
        drain("drain_drop");
        check("drop_1", 64'(drop_cnt), STATS ? 64'd1 : 64'd0);
        check_cnt("cnt_drop");

        // Ready toggling every cycle during a 4-beat frame.
        rmode = 2;
        send_frame(4, 8'hF0, 1'b0);
        drain("drain_toggle");
        check_cnt("cnt_toggle");

        // 16 committed frames with output stalled, then back-to-back.
        rmode = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_frame(1, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_ready", 64'(s_ready), 64'd0);
        check("full_valid", 64'(m_valid), 64'd1);
        rmode = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_valid && m_ready) && n < 20);
        run = 0;
        while (m_valid && m_ready && run < 20) begin
            run++;
            @(negedge clk);
        end
        check("b2b_run", 64'(run), 64'd16);
        drain("drain_b2b");
        check_cnt("cnt_b2b");

        // Randomized frames, gaps and output backpressure.
        rmode = 3;
        @(posedge clk);
        #1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) == 0)
                send_frame(1, 8'h00, 1'b1);
            else
                send_frame($urandom_range(1, 30), ktab[$urandom_range(0, 8)], 1'b1);
        end
        rmode = 0;
        drain("drain_rand");
        check_cnt("cnt_rand");

        // Reset mid-frame with a committed frame stalled at the output.
        rmode = 1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(1, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0, ok);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0, ok);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        frames_exp = 0;
        drop_exp = 0;
        #1;
        check("mid_rst_valid_last", 64'({m_valid, m_last}), 64'd0);
        check("mid_rst_ready", 64'(s_ready), 64'd0);
        check("mid_rst_data", m_data, 64'd0);
        check("mid_rst_user_keep", 64'({m_user, m_keep}), 64'd0);
        check("mid_rst_cnts", 64'({frame_cnt, drop_cnt}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rmode = 0;
        repeat (3) @(posedge clk);
        #1;
        send_frame(1, 8'hFF, 1'b0);
        drain("drain_after_rst");
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_frames", 64'(frame_cnt), STATS ? 64'd1 : 64'd0);
        check("post_rst_drops", 64'(drop_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
